// File: rtl/pe_cfg_pkg.sv
// rtl/pe_cfg_pkg.sv - widths, opcodes and instruction field positions for the PE config sequencer
package pe_cfg_pkg;

    localparam int INST_WIDTH      = 64;
    localparam int CONFIG_CMAC     = 16;
    localparam int CONFIG_LOGI     = 9;
    localparam int CONFIG_CORDIC   = 8;
    localparam int CONFIG_DMEM     = 31;
    localparam int CONFIG_ALL      = CONFIG_CMAC + CONFIG_LOGI + CONFIG_CORDIC + CONFIG_DMEM;

    localparam int NUM_INPUTS_CB1  = 14;
    localparam int NUM_OUTPUTS_CB1 = 16;
    localparam int NUM_INPUTS_CB2  = 10;
    localparam int NUM_OUTPUTS_CB2 = 4;
    localparam int CW1             = $clog2(NUM_INPUTS_CB1);
    localparam int CW2             = $clog2(NUM_INPUTS_CB2);
    localparam int CB1_IW          = $clog2(NUM_OUTPUTS_CB1);
    localparam int CB2_IW          = $clog2(NUM_OUTPUTS_CB2);

    // Widest unit word; WR_UNIT hands this many payload LSBs to the bank.
    localparam int UNIT_DW         = CONFIG_DMEM;

    // Instruction field positions.
    localparam int OPC_MSB         = 63;
    localparam int OPC_LSB         = 60;
    localparam int IDX_MSB         = 59;
    localparam int IDX_LSB         = 56;
    localparam int PAY_MSB         = 55;
    localparam int PAY_LSB         = 0;
    localparam int WAIT_MSB        = 15;

    localparam logic [1:0] UNIT_CMAC   = 2'd0;
    localparam logic [1:0] UNIT_LOGI   = 2'd1;
    localparam logic [1:0] UNIT_CORDIC = 2'd2;
    localparam logic [1:0] UNIT_DMEM   = 2'd3;

    typedef enum logic [3:0] {
        OP_NOP     = 4'd0,
        OP_WR_CB1  = 4'd1,
        OP_WR_CB2  = 4'd2,
        OP_WR_UNIT = 4'd3,
        OP_COMMIT  = 4'd4,
        OP_WAIT    = 4'd5
    } opcode_e;

endpackage

// File: rtl/pe_config_sequencer_if.sv
// rtl/pe_config_sequencer_if.sv - instruction handshake between the PE instruction FIFO and the sequencer
interface pe_config_sequencer_if;
    import pe_cfg_pkg::*;

    logic [INST_WIDTH-1:0] inst;
    logic                  inst_valid;
    logic                  inst_ready;

    modport master (output inst, output inst_valid, input inst_ready);
    modport slave  (input inst, input inst_valid, output inst_ready);

endinterface

// File: rtl/pe_cfg_bank.sv
// rtl/pe_cfg_bank.sv - shadow/active config register pair with a write port and a commit strobe
module pe_cfg_bank
    import pe_cfg_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cb1_we,
    input  logic [CB1_IW-1:0]                 cb1_idx,
    input  logic [CW1-1:0]                    cb1_sel,
    input  logic                              cb2_we,
    input  logic [CB2_IW-1:0]                 cb2_idx,
    input  logic [CW2-1:0]                    cb2_sel,
    input  logic                              unit_we,
    input  logic [1:0]                        unit_idx,
    input  logic [UNIT_DW-1:0]                unit_data,
    input  logic                              commit,
    output logic [CONFIG_ALL-1:0]             config_all,
    output logic [NUM_OUTPUTS_CB1*CW1-1:0]    config_cb1,
    output logic [NUM_OUTPUTS_CB2*CW2-1:0]    config_cb2
);

    logic [CW1-1:0]           sh_cb1 [NUM_OUTPUTS_CB1];
    logic [CW1-1:0]           act_cb1 [NUM_OUTPUTS_CB1];
    logic [CW2-1:0]           sh_cb2 [NUM_OUTPUTS_CB2];
    logic [CW2-1:0]           act_cb2 [NUM_OUTPUTS_CB2];
    logic [CONFIG_CMAC-1:0]   sh_cmac, act_cmac;
    logic [CONFIG_LOGI-1:0]   sh_logi, act_logi;
    logic [CONFIG_CORDIC-1:0] sh_cordic, act_cordic;
    logic [CONFIG_DMEM-1:0]   sh_dmem, act_dmem;

    // Shadow copy: updated by decoded writes, persists across commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUTPUTS_CB1; i++) sh_cb1[i] <= '0;
            for (int i = 0; i < NUM_OUTPUTS_CB2; i++) sh_cb2[i] <= '0;
            sh_cmac   <= '0;
            sh_logi   <= '0;
            sh_cordic <= '0;
            sh_dmem   <= '0;
        end else begin
            if (cb1_we) sh_cb1[cb1_idx] <= cb1_sel;
            if (cb2_we) sh_cb2[cb2_idx] <= cb2_sel;
            if (unit_we) begin
                case (unit_idx)
                    UNIT_CMAC:   sh_cmac   <= unit_data[CONFIG_CMAC-1:0];
                    UNIT_LOGI:   sh_logi   <= unit_data[CONFIG_LOGI-1:0];
                    UNIT_CORDIC: sh_cordic <= unit_data[CONFIG_CORDIC-1:0];
                    default:     sh_dmem   <= unit_data[CONFIG_DMEM-1:0];
                endcase
            end
        end
    end

    // Active copy: every field takes the shadow value on the same commit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUTPUTS_CB1; i++) act_cb1[i] <= '0;
            for (int i = 0; i < NUM_OUTPUTS_CB2; i++) act_cb2[i] <= '0;
            act_cmac   <= '0;
            act_logi   <= '0;
            act_cordic <= '0;
            act_dmem   <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_OUTPUTS_CB1; i++) act_cb1[i] <= sh_cb1[i];
            for (int i = 0; i < NUM_OUTPUTS_CB2; i++) act_cb2[i] <= sh_cb2[i];
            act_cmac   <= sh_cmac;
            act_logi   <= sh_logi;
            act_cordic <= sh_cordic;
            act_dmem   <= sh_dmem;
        end
    end

    assign config_all = {act_cmac, act_cordic, act_logi, act_dmem};

    for (genvar g = 0; g < NUM_OUTPUTS_CB1; g++) begin : g_cb1
        assign config_cb1[g*CW1 +: CW1] = act_cb1[g];
    end

    for (genvar g = 0; g < NUM_OUTPUTS_CB2; g++) begin : g_cb2
        assign config_cb2[g*CW2 +: CW2] = act_cb2[g];
    end

endmodule

// File: rtl/pe_config_sequencer.sv
// rtl/pe_config_sequencer.sv - decodes config instructions into a shadow bank and commits it when the datapath is idle
module pe_config_sequencer
    import pe_cfg_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst,
    pe_config_sequencer_if.slave              inst_bus,
    input  logic                              dp_idle,
    output logic [CONFIG_ALL-1:0]             config_all,
    output logic [NUM_OUTPUTS_CB1*CW1-1:0]    config_cb1,
    output logic [NUM_OUTPUTS_CB2*CW2-1:0]    config_cb2,
    output logic                              cfg_valid,
    output logic                              commit_done,
    output logic                              busy,
    output logic                              err
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]             state;
    logic [WAIT_MSB:0]      cnt;
    logic [3:0]             opc;
    logic [3:0]             idx;
    logic [PAY_MSB:PAY_LSB] pay;
    logic                   accept;
    logic                   cb1_we, cb2_we, unit_we;
    logic                   bad_inst, go_commit, go_wait;
    logic                   commit_strobe;
    logic                   unused_pay;

    assign opc    = inst_bus.inst[OPC_MSB:OPC_LSB];
    assign idx    = inst_bus.inst[IDX_MSB:IDX_LSB];
    assign pay    = inst_bus.inst[PAY_MSB:PAY_LSB];

    // Payload bits above the widest unit word carry no meaning.
    assign unused_pay = ^pay[PAY_MSB:UNIT_DW];

    assign inst_bus.inst_ready = (state == ST_RUN);
    assign accept        = inst_bus.inst_valid && (state == ST_RUN);
    assign busy          = (state != ST_RUN);
    assign commit_strobe = (state == ST_COMMIT) && dp_idle;

    // Decode the accepted instruction into write enables, FSM requests and the illegal flag.
    always_comb begin
        cb1_we    = 1'b0;
        cb2_we    = 1'b0;
        unit_we   = 1'b0;
        bad_inst  = 1'b0;
        go_commit = 1'b0;
        go_wait   = 1'b0;
        if (accept) begin
            case (opc)
                OP_NOP: ;
                OP_WR_CB1: begin
                    if (int'(idx) >= NUM_OUTPUTS_CB1 || int'(pay[CW1-1:0]) >= NUM_INPUTS_CB1)
                        bad_inst = 1'b1;
                    else
                        cb1_we = 1'b1;
                end
                OP_WR_CB2: begin
                    if (int'(idx) >= NUM_OUTPUTS_CB2 || int'(pay[CW2-1:0]) >= NUM_INPUTS_CB2)
                        bad_inst = 1'b1;
                    else
                        cb2_we = 1'b1;
                end
                OP_WR_UNIT: begin
                    if (int'(idx) > int'(UNIT_DMEM))
                        bad_inst = 1'b1;
                    else
                        unit_we = 1'b1;
                end
                OP_COMMIT: go_commit = 1'b1;
                OP_WAIT:   go_wait   = (pay[WAIT_MSB:0] != '0);
                default:   bad_inst  = 1'b1;
            endcase
        end
    end

    // Sequencer FSM: RUN accepts instructions, WAIT counts down, COMMIT holds until the datapath is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            cfg_valid   <= 1'b0;
            commit_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            if (bad_inst) err <= 1'b1;
            case (state)
                ST_RUN: begin
                    if (go_commit) begin
                        state <= ST_COMMIT;
                    end else if (go_wait) begin
                        cnt   <= pay[WAIT_MSB:0];
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) state <= ST_RUN;
                end
                ST_COMMIT: begin
                    if (dp_idle) begin
                        state       <= ST_RUN;
                        commit_done <= 1'b1;
                        cfg_valid   <= 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    pe_cfg_bank u_bank (
        .clk        (clk),
        .rst        (rst),
        .cb1_we     (cb1_we),
        .cb1_idx    (idx[CB1_IW-1:0]),
        .cb1_sel    (pay[CW1-1:0]),
        .cb2_we     (cb2_we),
        .cb2_idx    (idx[CB2_IW-1:0]),
        .cb2_sel    (pay[CW2-1:0]),
        .unit_we    (unit_we),
        .unit_idx   (idx[1:0]),
        .unit_data  (pay[UNIT_DW-1:0]),
        .commit     (commit_strobe),
        .config_all (config_all),
        .config_cb1 (config_cb1),
        .config_cb2 (config_cb2)
    );

endmodule

// File: doc/pe_config_sequencer.md
Name: pe_config_sequencer

Overview:
Sequences PE configuration from a stream of 64-bit config instructions delivered over a valid/ready handshake.
- Instructions write a shadow copy of every config field: CMAC, LOGI, CORDIC and DMEM unit words, CB1 output selects and CB2 output selects.
- A COMMIT instruction copies shadow to active atomically, but only while the datapath reports idle.
- Sits between the PE instruction FIFO and the PE datapath/crossbars; the active registers drive the units directly.

Parameters:
- INST_WIDTH, 64, instruction width.
- CONFIG_CMAC, 16, CMAC config width.
- CONFIG_LOGI, 9, logical-unit config width.
- CONFIG_CORDIC, 8, CORDIC config width.
- CONFIG_DMEM, 31, DMEM config width.
- CONFIG_ALL, sum of the four, concatenated unit config width.
- NUM_INPUTS_CB1, 14, CB1 inputs; select width CW1 = $clog2(NUM_INPUTS_CB1).
- NUM_OUTPUTS_CB1, 16, CB1 outputs.
- NUM_INPUTS_CB2, 10, CB2 inputs; select width CW2 = $clog2(NUM_INPUTS_CB2).
- NUM_OUTPUTS_CB2, 4, CB2 outputs.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- inst, input, INST_WIDTH, config instruction.
- inst_valid, input, 1, inst is valid.
- inst_ready, output, 1, sequencer accepts inst this cycle.
- dp_idle, input, 1, datapath idle; commit is allowed.
- config_all, output, CONFIG_ALL, active {cmac, cordic, logi, dmem}.
- config_cb1, output, NUM_OUTPUTS_CB1 x CW1, active CB1 selects (packed).
- config_cb2, output, NUM_OUTPUTS_CB2 x CW2, active CB2 selects (packed).
- cfg_valid, output, 1, at least one commit since reset.
- commit_done, output, 1, one-cycle pulse after the active registers update.
- busy, output, 1, sequencer is in WAIT or COMMIT.
- err, output, 1, sticky illegal-instruction flag.

Behaviour:
Clocking and reset:
- One clock; reset is synchronous and active-high.
- Reset: all shadow and active registers 0, state RUN, cfg_valid=0, commit_done=0, err=0, busy=0.
- Reset mid-WAIT or mid-COMMIT aborts the operation; active registers clear to 0.

Handshake:
- Accept occurs when inst_valid && inst_ready.
- inst_ready = (state==RUN); it is not combinationally dependent on inst_valid.

Instruction format:
- opc = inst[63:60], idx = inst[59:56], pay = inst[55:0].

Opcodes:
- 0 NOP: no effect.
- 1 WR_CB1: shadow_cb1[idx] <= pay[CW1-1:0]. idx>=NUM_OUTPUTS_CB1 or sel>=NUM_INPUTS_CB1 -> no write, err<=1.
- 2 WR_CB2: shadow_cb2[idx] <= pay[CW2-1:0]. idx>=4 or sel>=10 -> no write, err<=1.
- 3 WR_UNIT: writes the LSBs of pay. idx 0=CMAC, 1=LOGI, 2=CORDIC, 3=DMEM. idx>3 -> err<=1.
- 4 COMMIT: go to state COMMIT.
- 5 WAIT: n = pay[15:0]. n==0 behaves as NOP; otherwise cnt<=n and go to WAIT.
- 6..15: no effect, err<=1.

Latency:
- A shadow write accepted at cycle t is visible in shadow at t+1.
- Shadow is never visible on the outputs until a commit.

FSM:
- RUN -> COMMIT on an accepted COMMIT.
- RUN -> WAIT on an accepted WAIT with n>0.
- WAIT: decrement cnt each cycle; return to RUN when cnt==1. inst_ready is therefore low for exactly n cycles.
- COMMIT: on any cycle with dp_idle=1, active <= shadow (all fields in the same edge) and cfg_valid<=1.
  - commit_done pulses high the following cycle; return to RUN in the same edge.
  - With dp_idle=0, hold indefinitely; no timeout.
- Minimum commit cost: accept at t, active updated at t+1 edge, commit_done high during t+2, next accept at t+2.
- busy = (state != RUN).

Boundary rules:
- Shadow persists across commits; it is not cleared after a commit.
- Back-to-back writes to the same field: the last write wins.
- Consecutive COMMITs with no intervening writes re-copy identical data and are legal.
- err is sticky until rst; an erroring instruction is still consumed and does not stall.

Decomposition:
- Package pe_cfg_pkg holds:
  - the opcode enum (NOP, WR_CB1, WR_CB2, WR_UNIT, COMMIT, WAIT);
  - unit-index constants (UNIT_CMAC=0, UNIT_LOGI=1, UNIT_CORDIC=2, UNIT_DMEM=3);
  - the field bit positions;
  - the default widths.
- One sub-module, pe_cfg_bank: the shadow and active register pair with a write port and a commit strobe, instantiated once.
- The FSM and decode stay in the top level.

Test Plan:
- Reset, then WR_CB1 idx=5 sel=13, then COMMIT with dp_idle=1 -> config_cb1[5]=13, all other selects 0; commit_done pulses once; cfg_valid=1.
- WR_UNIT idx=0 pay=0xBEEF, no COMMIT -> config_all unchanged (0); after COMMIT, config_all[CONFIG_ALL-1 -: 16]=0xBEEF.
- COMMIT with dp_idle=0 for 10 cycles, then 1 -> inst_ready=0 and busy=1 for those cycles; active updates on the first idle cycle; commit_done high exactly one cycle later.
- WAIT n=3 with inst_valid held high -> inst_ready low exactly 3 cycles; WAIT n=0 -> next instruction accepted the following cycle.
- WR_CB1 sel=14, WR_CB2 idx=4, opc=9 -> err=1 after the first; no shadow change (verified by a following COMMIT); each instruction consumed in one cycle.
- Assert rst during COMMIT wait after prior commit of 0xBEEF -> all outputs 0, cfg_valid=0, inst_ready=1 the next cycle.
